recon_datapath: RTL and testbench

//  Iterative CORDIC datapath driven by recon_controlpath (selmx/selmy/selmz, i).

---
 rtl/recon_pkg.sv | 32 +++
 rtl/recon_datapath_atan_rom.sv | 32 +++
 rtl/recon_datapath.sv | 152 +++++++++++++++
 tb/tb_recon_datapath.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/recon_pkg.sv
// ---------------------------------------------------------------------------
// recon_pkg
//   Shared definitions for the iterative CORDIC reconfigurable datapath:
//   default word/fraction widths, mode codes, the circular gain prescale
//   constant and the first/last control-path iteration indices.
// ---------------------------------------------------------------------------
package recon_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_FRAC  = 12;

    typedef enum logic [1:0] {
        MODE_LROT = 2'b00,  // linear rotation: y += x*z (multiply)
        MODE_LVEC = 2'b01,  // linear vectoring: z += y/x (divide)
        MODE_CROT = 2'b10,  // circular rotation: rotate (x,y) by z radians
        MODE_RSVD = 2'b11   // reserved, behaves as linear rotation
    } mode_e;

    // 1/K for nine circular micro-rotations, Q4.12. The datapath does not
    // compensate the gain; callers prescale x_in by this value.
    localparam int K9 = 2487;

    // Control-path iteration indices that carry micro-rotations k = i - 2.
    localparam logic [3:0] ITER_FIRST = 4'd2;
    localparam logic [3:0] ITER_LAST  = 4'd10;

    // The reserved code is folded onto linear rotation when it is latched.
    function automatic mode_e decode_mode(input logic [1:0] m);
        return (m == 2'b11) ? MODE_LROT : mode_e'(m);
    endfunction

endpackage

// File: rtl/recon_datapath_atan_rom.sv
// ---------------------------------------------------------------------------
// cordic_atan_rom
//   Combinational lookup of atan(2^-k) in Q4.12 radians for k = 0..8.
//   Indices above 8 return 0 so out-of-range iterations never move Z.
// Ports
//   k    in   4      micro-rotation index
//   atan out  WIDTH  atan(2^-k), Q4.12
// ---------------------------------------------------------------------------
module cordic_atan_rom #(
    parameter int WIDTH = 16
) (
    input  logic [3:0]       k,
    output logic [WIDTH-1:0] atan
);

    always_comb begin
        atan = '0;
        case (k)
            4'd0:    atan = WIDTH'(3217);
            4'd1:    atan = WIDTH'(1899);
            4'd2:    atan = WIDTH'(1003);
            4'd3:    atan = WIDTH'(509);
            4'd4:    atan = WIDTH'(256);
            4'd5:    atan = WIDTH'(128);
            4'd6:    atan = WIDTH'(64);
            4'd7:    atan = WIDTH'(32);
            4'd8:    atan = WIDTH'(16);
            default: atan = '0;
        endcase
    end

endmodule

// File: rtl/recon_datapath.sv
// ---------------------------------------------------------------------------
// recon_datapath
//   Iterative CORDIC datapath. While a register's select is low it loads its
//   operand; while high (and 2 <= i <= 10) it performs micro-rotation k = i-2.
//   When selmx falls after an iteration run, the finished X/Y/Z are copied to
//   the output bank with a one-cycle out_valid pulse, on the same edge that the
//   next frame's operands load.
// Ports
//   clk, reset            clock, synchronous active-high reset
//   selmx/selmy/selmz     per-register 0: load, 1: iterate
//   i [3:0]               iteration counter from the control path
//   mode [1:0]            00 lin-rot, 01 lin-vec, 10 circ-rot, 11 as 00
//   x_in/y_in/z_in        operands (Q4.12)
//   x_out/y_out/z_out     results, held until the next frame completes
//   out_valid             one-cycle pulse when the results update
// ---------------------------------------------------------------------------
module recon_datapath
    import recon_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int FRAC  = DEF_FRAC
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             selmx,
    input  logic             selmy,
    input  logic             selmz,
    input  logic [3:0]       i,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] x_in,
    input  logic [WIDTH-1:0] y_in,
    input  logic [WIDTH-1:0] z_in,
    output logic [WIDTH-1:0] x_out,
    output logic [WIDTH-1:0] y_out,
    output logic [WIDTH-1:0] z_out,
    output logic             out_valid
);

    // Working registers
    logic signed [WIDTH-1:0] x_q, x_d;
    logic signed [WIDTH-1:0] y_q, y_d;
    logic signed [WIDTH-1:0] z_q, z_d;
    mode_e                   mode_q, mode_d;
    // Previous-edge selmx, used to detect the end of an iteration run
    logic                    sel_dly_q, sel_dly_d;

    // Output bank
    logic [WIDTH-1:0]        x_out_q, x_out_d;
    logic [WIDTH-1:0]        y_out_q, y_out_d;
    logic [WIDTH-1:0]        z_out_q, z_out_d;
    logic                    out_valid_q, out_valid_d;

    // Iteration datapath
    logic                    iter_active;
    logic [3:0]              k_idx;
    logic [4:0]              lin_shamt;
    logic [WIDTH-1:0]        atan_val;
    logic signed [WIDTH-1:0] x_shift, y_shift;
    logic signed [WIDTH-1:0] lin_step, z_step;
    logic signed [WIDTH-1:0] x_iter, y_iter, z_iter;
    logic                    is_vec, is_circ;
    logic                    d_pos;
    logic                    frame_done;

    cordic_atan_rom #(
        .WIDTH (WIDTH)
    ) u_atan_rom (
        .k    (k_idx),
        .atan (atan_val)
    );

    always_comb begin
        iter_active = (i >= ITER_FIRST) && (i <= ITER_LAST);
        k_idx       = i - ITER_FIRST;

        // Barrel shifters; arithmetic so negative values round toward -inf
        x_shift = x_q >>> k_idx;
        y_shift = y_q >>> k_idx;

        // Linear-mode Z step is 2^-k in Q format, i.e. 1 << (FRAC-k)
        lin_shamt = 5'(FRAC) - {1'b0, k_idx};
        lin_step  = WIDTH'(1) << lin_shamt;

        is_vec  = (mode_q == MODE_LVEC);
        is_circ = (mode_q == MODE_CROT);

        // Direction from the pre-update values: vectoring drives Y toward 0,
        // rotation drives Z toward 0.
        d_pos = is_vec ? y_q[WIDTH-1] : ~z_q[WIDTH-1];

        z_step = is_circ ? $signed(atan_val) : lin_step;

        // Linear modes leave X untouched
        x_iter = x_q;
        if (is_circ) begin
            x_iter = d_pos ? (x_q - y_shift) : (x_q + y_shift);
        end
        y_iter = d_pos ? (y_q + x_shift) : (y_q - x_shift);
        z_iter = d_pos ? (z_q - z_step)  : (z_q + z_step);

        // Each register follows its own select; iterate outside 2..10 holds
        x_d = x_q;
        y_d = y_q;
        z_d = z_q;
        if (!selmx)           x_d = x_in;
        else if (iter_active) x_d = x_iter;
        if (!selmy)           y_d = y_in;
        else if (iter_active) y_d = y_iter;
        if (!selmz)           z_d = z_in;
        else if (iter_active) z_d = z_iter;

        mode_d = selmz ? mode_q : decode_mode(mode);

        // Falling selmx marks the end of a frame; capture before the reload
        sel_dly_d   = selmx;
        frame_done  = !selmx && sel_dly_q;
        out_valid_d = frame_done;
        x_out_d     = frame_done ? x_q : x_out_q;
        y_out_d     = frame_done ? y_q : y_out_q;
        z_out_d     = frame_done ? z_q : z_out_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            mode_q      <= MODE_LROT;
            sel_dly_q   <= 1'b0;
            x_out_q     <= '0;
            y_out_q     <= '0;
            z_out_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            x_q         <= x_d;
            y_q         <= y_d;
            z_q         <= z_d;
            mode_q      <= mode_d;
            sel_dly_q   <= sel_dly_d;
            x_out_q     <= x_out_d;
            y_out_q     <= y_out_d;
            z_out_q     <= z_out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign x_out     = x_out_q;
    assign y_out     = y_out_q;
    assign z_out     = z_out_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_recon_datapath.sv
// ---------------------------------------------------------------------------
// tb_recon_datapath
//   Directed bench for recon_datapath. The control-path frame sequence is
//   driven directly; each frame pushes its reference result onto a queue and
//   the pulse from the DUT pops and compares it. Outputs are checked on every
//   cycle for out_valid timing and for holding between frames.
// ---------------------------------------------------------------------------
module tb_recon_datapath;
    import recon_pkg::*;

    localparam int W = DEF_WIDTH;

    typedef struct packed {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] z;
    } res_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         selmx, selmy, selmz;
    logic [3:0]   i;
    logic [1:0]   mode;
    logic [W-1:0] x_in, y_in, z_in;
    logic [W-1:0] x_out, y_out, z_out;
    logic         out_valid;

    res_t exp_q[$];
    res_t held;
    logic last_sel;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   atan_tab[9] = '{3217, 1899, 1003, 509, 256, 128, 64, 32, 16};

    recon_datapath dut (
        .clk       (clk),
        .reset     (reset),
        .selmx     (selmx),
        .selmy     (selmy),
        .selmz     (selmz),
        .i         (i),
        .mode      (mode),
        .x_in      (x_in),
        .y_in      (y_in),
        .z_in      (z_in),
        .x_out     (x_out),
        .y_out     (y_out),
        .z_out     (z_out),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    function automatic int wrap(input int v);
        logic signed [W-1:0] t;
        t = v[W-1:0];
        return int'(t);
    endfunction

    // Reference CORDIC written straight from the micro-rotation equations
    function automatic res_t model(input int x0, input int y0, input int z0,
                                   input logic [1:0] m);
        int   x, y, z, nx, ny, nz, step;
        logic pos;
        res_t r;
        x = wrap(x0);
        y = wrap(y0);
        z = wrap(z0);
        for (int k = 0; k <= 8; k++) begin
            pos = (m == 2'b01) ? (y < 0) : (z >= 0);
            if (m == 2'b10) begin
                nx   = pos ? x - (y >>> k) : x + (y >>> k);
                step = atan_tab[k];
            end else begin
                nx   = x;
                step = 1 << (DEF_FRAC - k);
            end
            ny = pos ? y + (x >>> k) : y - (x >>> k);
            nz = pos ? z - step : z + step;
            x  = wrap(nx);
            y  = wrap(ny);
            z  = wrap(nz);
        end
        r.x = x[W-1:0];
        r.y = y[W-1:0];
        r.z = z[W-1:0];
        return r;
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs,
                         input logic [W-1:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d (0x%h), expected %0d (0x%h)",
                   tag, $signed(obs), obs, $signed(expv), expv);
        end
    endtask

    task automatic check_tol(input string tag, input logic [W-1:0] obs,
                             input int target, input int tol);
        int   diff;
        logic ok;
        diff = int'($signed(obs)) - target;
        ok   = (diff <= tol) && (diff >= -tol);
        n_tests++;
        assert (ok === 1'b1) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d +/- %0d",
                   tag, $signed(obs), target, tol);
        end
    endtask

    // One clock; the expected pulse is derived from the inputs on that edge
    task automatic tick();
        logic ev;
        ev = !reset && !selmx && last_sel;
        @(posedge clk);
        #1;
        if (reset) begin
            last_sel = 1'b0;
            held     = '0;
        end else begin
            last_sel = selmx;
            if (ev) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $error("FAIL scoreboard_underflow: observed pulse, expected no pending frame");
                end else begin
                    held = exp_q.pop_front();
                end
            end
        end
        check("out_valid", W'(out_valid), W'(ev));
        check("x_out", x_out, held.x);
        check("y_out", y_out, held.y);
        check("z_out", z_out, held.z);
        if (out_valid)
            $display("[TB] frame result x=%0d y=%0d z=%0d", $signed(x_out),
                     $signed(y_out), $signed(z_out));
    endtask

    task automatic set_sel(input logic s, input logic [3:0] iv);
        selmx = s;
        selmy = s;
        selmz = s;
        i     = iv;
    endtask

    task automatic idle();
        set_sel(1'b0, 4'd0);
        tick();
    endtask

    // Full frame: i=0,1 load, i=2..10 iterate. abort_at>0 asserts reset
    // during that iteration cycle and drops the frame's expectation.
    task automatic run_frame(input int xv, input int yv, input int zv,
                             input logic [1:0] m, input int abort_at);
        exp_q.push_back(model(xv, yv, zv, m));
        x_in = xv[W-1:0];
        y_in = yv[W-1:0];
        z_in = zv[W-1:0];
        mode = m;
        set_sel(1'b0, 4'd0);
        tick();
        set_sel(1'b0, 4'd1);
        tick();
        for (int it = 2; it <= 10; it++) begin
            // Operands and mode must be ignored while iterating
            x_in = W'($urandom);
            y_in = W'($urandom);
            z_in = W'($urandom);
            mode = 2'($urandom_range(0, 3));
            set_sel(1'b1, 4'(it));
            if (it == abort_at) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
                void'(exp_q.pop_back());
                return;
            end
            tick();
        end
    endtask

    initial begin
        held     = '0;
        last_sel = 1'b0;
        reset    = 1'b1;
        x_in     = '0;
        y_in     = '0;
        z_in     = '0;
        mode     = 2'b00;
        set_sel(1'b0, 4'd0);
        tick();
        tick();
        reset = 1'b0;

        // Multiply 0.5 * 0.75
        run_frame(2048, 0, 3072, MODE_LROT, -1);
        idle();
        check_tol("lrot_y", y_out, 1536, 8);
        check("lrot_x", x_out, 16'd2048);
        idle();
        idle();

        // Divide 0.5 / 1.0
        run_frame(4096, 2048, 0, MODE_LVEC, -1);
        idle();
        check_tol("lvec_z", z_out, 2048, 16);
        check_tol("lvec_y", y_out, 0, 16);

        // Rotate (K9, 0) by pi/4. Nine iterations leave ~13 LSB of residual
        // angle, which puts y about 10 LSB below cos(pi/4).
        run_frame(K9, 0, 3217, MODE_CROT, -1);
        idle();
        check_tol("crot_x", x_out, 2896, 16);
        check_tol("crot_y", y_out, 2896, 16);
        check_tol("crot_z", z_out, 0, 16);
        idle();

        // Abort at i=5: outputs clear, no pulse, next frame still correct
        run_frame(1000, -500, 2000, MODE_LROT, 5);
        run_frame(K9, 1000, -1500, MODE_CROT, -1);
        idle();

        // Back-to-back frames with changing mode, including the reserved code
        run_frame(3000, -4000, 0, MODE_LVEC, -1);
        run_frame(-1200, 700, 2500, MODE_CROT, -1);
        run_frame(-2048, 100, -3072, MODE_RSVD, -1);
        run_frame(1500, 300, -800, MODE_LROT, -1);
        for (int r = 0; r < 6; r++) begin
            run_frame(int'($urandom_range(0, 8191)) - 4096,
                      int'($urandom_range(0, 8191)) - 4096,
                      int'($urandom_range(0, 8191)) - 4096,
                      2'($urandom_range(0, 3)), -1);
        end
        idle();
        idle();
        idle();

        check("scoreboard_empty", W'(exp_q.size()), '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
